// File: rtl/fb_port_arb_if.sv
// fb_port_arb_if
//   Bundles the frame-buffer arbiter's requester and RAM-side signals.
//   slave  : arbiter view (requests in, RAM port and responses out)
//   master : requester/RAM view (the reverse directions)
//   Signals:
//     wr_req/wr_addr/wr_data   pixel-packer write strobe, address, data
//     rd_req/rd_addr           scan-out read strobe and address
//     rd_data/rd_valid         read response
//     rd_miss                  read dropped in favour of a forced write
//     wr_ovf/ovf_clr           sticky write-overflow flag and its clear
//     ram_addr/ram_we/ram_wdata/ram_rdata  single-port RAM connection
//   Optional (ARB_STAT_EN): stat_wr_cnt, stat_drop_cnt, stat_miss_cnt.
interface fb_port_arb_if;
    logic        wr_req;
    logic [15:0] wr_addr;
    logic [15:0] wr_data;
    logic        rd_req;
    logic [15:0] rd_addr;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic        rd_miss;
    logic        wr_ovf;
    logic        ovf_clr;
    logic [15:0] ram_addr;
    logic        ram_we;
    logic [15:0] ram_wdata;
    logic [15:0] ram_rdata;
`ifdef ARB_STAT_EN
    logic [31:0] stat_wr_cnt;
    logic [15:0] stat_drop_cnt;
    logic [15:0] stat_miss_cnt;
`endif

    modport slave (
        input  wr_req, wr_addr, wr_data, rd_req, rd_addr, ovf_clr, ram_rdata,
        output rd_data, rd_valid, rd_miss, wr_ovf, ram_addr, ram_we, ram_wdata
`ifdef ARB_STAT_EN
        , output stat_wr_cnt, stat_drop_cnt, stat_miss_cnt
`endif
    );

    modport master (
        output wr_req, wr_addr, wr_data, rd_req, rd_addr, ovf_clr, ram_rdata,
        input  rd_data, rd_valid, rd_miss, wr_ovf, ram_addr, ram_we, ram_wdata
`ifdef ARB_STAT_EN
        , input stat_wr_cnt, stat_drop_cnt, stat_miss_cnt
`endif
    );
endinterface

// File: rtl/fb_port_arb.sv
// fb_port_arb
//   Shares one single-port frame-buffer RAM between the UART pixel packer
//   (writes) and the real-time VGA scan-out (reads). Reads win; writes wait
//   in a small first-word-fall-through FIFO and drain on cycles without a
//   read. If the FIFO has been blocked for STARVE_MAX cycles, the next read
//   is dropped (rd_miss) and a write is forced instead.
//   Ports:
//     clk   system clock
//     rst   asynchronous, active-high reset
//     bus   fb_port_arb_if.slave (requests, responses, RAM port)
//   Parameters:
//     WFIFO_DEPTH  write FIFO entries (power of 2, >=2)
//     RD_LAT       RAM read latency from registered ram_addr (1..3)
//     STARVE_MAX   blocked cycles before a write is forced (>=1)
//   Optional feature macro ARB_STAT_EN adds wrapping statistics counters.
//
//   state    | meaning
//   GNT_IDLE | RAM port idle, address/data hold
//   GNT_RD   | read issued to the RAM this cycle
//   GNT_WR   | FIFO head written to the RAM this cycle
module fb_port_arb #(
    parameter int WFIFO_DEPTH = 4,
    parameter int RD_LAT      = 1,
    parameter int STARVE_MAX  = 64
) (
    input  logic          clk,
    input  logic          rst,
    fb_port_arb_if.slave  bus
);
    localparam int PW = $clog2(WFIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {GNT_IDLE, GNT_RD, GNT_WR} gnt_t;

    gnt_t grant, grant_nxt;

    logic [15:0]   fifo_addr [WFIFO_DEPTH];
    logic [15:0]   fifo_data [WFIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          fifo_empty, fifo_full;
    logic          push, pop, drop, forced;

    logic [SW-1:0] starve_cnt;
    logic [RD_LAT:0] rd_pipe;
    logic [15:0]   rd_data_q;
    logic          rd_miss_q, wr_ovf_q;
    logic [15:0]   ram_addr_q, ram_wdata_q;

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == CW'(WFIFO_DEPTH));

    // Next grant and the FIFO handshakes that follow from it.
    always_comb begin
        grant_nxt = GNT_IDLE;
        forced    = 1'b0;
        if (bus.rd_req) begin
            if (starve_cnt == SW'(STARVE_MAX) && !fifo_empty) begin
                grant_nxt = GNT_WR;
                forced    = 1'b1;
            end else begin
                grant_nxt = GNT_RD;
            end
        end else if (!fifo_empty) begin
            grant_nxt = GNT_WR;
        end
        pop  = (grant_nxt == GNT_WR);
        // A full FIFO still accepts a word when its head leaves this cycle.
        push = bus.wr_req && (!fifo_full || pop);
        drop = bus.wr_req && fifo_full && !pop;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) grant <= GNT_IDLE;
        else     grant <= grant_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            rd_miss_q   <= 1'b0;
        end else begin
            rd_miss_q <= forced;
            case (grant_nxt)
                GNT_RD: ram_addr_q <= bus.rd_addr;
                GNT_WR: begin
                    ram_addr_q  <= fifo_addr[rd_ptr];
                    ram_wdata_q <= fifo_data[rd_ptr];
                end
                default: ;
            endcase
        end
    end

    // Storage needs no reset; pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= bus.wr_addr;
            fifo_data[wr_ptr] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            starve_cnt <= '0;
        else if (fifo_empty || pop)
            starve_cnt <= '0;
        else if (starve_cnt != SW'(STARVE_MAX))
            starve_cnt <= starve_cnt + SW'(1);
    end

    // Set wins over clear when both land in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)              wr_ovf_q <= 1'b0;
        else if (drop)        wr_ovf_q <= 1'b1;
        else if (bus.ovf_clr) wr_ovf_q <= 1'b0;
    end

    // rd_pipe[0] marks the cycle ram_addr carries a read; bit RD_LAT is the
    // cycle the RAM presents its data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_pipe   <= '0;
            rd_data_q <= '0;
        end else begin
            rd_pipe <= {rd_pipe[RD_LAT-1:0], (grant_nxt == GNT_RD)};
            if (rd_pipe[RD_LAT]) rd_data_q <= bus.ram_rdata;
        end
    end

    assign bus.rd_valid  = rd_pipe[RD_LAT];
    assign bus.rd_data   = rd_pipe[RD_LAT] ? bus.ram_rdata : rd_data_q;
    assign bus.rd_miss   = rd_miss_q;
    assign bus.wr_ovf    = wr_ovf_q;
    assign bus.ram_addr  = ram_addr_q;
    assign bus.ram_wdata = ram_wdata_q;
    // Decoded from the state register so reset drops it immediately.
    assign bus.ram_we    = (grant == GNT_WR);

`ifdef ARB_STAT_EN
    logic [31:0] stat_wr_q;
    logic [15:0] stat_drop_q, stat_miss_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_wr_q   <= '0;
            stat_drop_q <= '0;
            stat_miss_q <= '0;
        end else begin
            if (pop)    stat_wr_q   <= stat_wr_q + 32'd1;
            if (drop)   stat_drop_q <= stat_drop_q + 16'd1;
            if (forced) stat_miss_q <= stat_miss_q + 16'd1;
        end
    end

    assign bus.stat_wr_cnt   = stat_wr_q;
    assign bus.stat_drop_cnt = stat_drop_q;
    assign bus.stat_miss_cnt = stat_miss_q;
`endif
endmodule

// File: tb/tb_fb_port_arb.sv
module tb_fb_port_arb;
    localparam int DEPTH      = 4;
    localparam int RD_LAT     = 1;
    localparam int STARVE_MAX = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [31:0] cyc = 32'd0;

    fb_port_arb_if bus();

    fb_port_arb #(.WFIFO_DEPTH(DEPTH), .RD_LAT(RD_LAT), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 32'd1;

    function automatic logic [15:0] init_val(input logic [15:0] a);
        return (a == 16'h0010) ? 16'h1234 : (a ^ 16'hC3A5);
    endfunction

    // Behavioural single-port RAM with RD_LAT read latency.
    logic [15:0] ram_mem [0:255];
    logic [15:0] rq [0:RD_LAT-1];
    bit ram_init = 1'b0;
    always @(posedge clk) begin
        if (!ram_init) begin
            for (int i = 0; i < 256; i++) ram_mem[i] <= init_val(16'(i));
            ram_init <= 1'b1;
        end else if (bus.ram_we) begin
            ram_mem[bus.ram_addr[7:0]] <= bus.ram_wdata;
        end
        rq[0] <= ram_mem[bus.ram_addr[7:0]];
        for (int i = 1; i < RD_LAT; i++) rq[i] <= rq[i-1];
    end
    assign bus.ram_rdata = rq[RD_LAT-1];

    // Scoreboard and reference model state.
    typedef struct packed { logic [15:0] addr; logic [15:0] data; } fent_t;
    typedef struct packed { logic [15:0] addr; logic [15:0] data; logic forced; logic [31:0] cyc; } wexp_t;
    typedef struct packed { logic [15:0] data; logic [31:0] cyc; } rexp_t;

    fent_t mq[$];
    wexp_t exp_wr[$];
    rexp_t exp_rd[$];
    logic [15:0] mmem [0:255];
    int   waited = 0;
    logic exp_ovf = 1'b0;
    int   nassert = 0;
    int   nfail = 0;
    int   n_miss_seen = 0;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        nassert++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name, input string what);
        nassert++;
        nfail++;
        $display("FAIL %s: %s (cycle %0d)", name, what, cyc);
    endtask

    // One arbitration cycle of the reference: reads win unless the FIFO has
    // waited STARVE_MAX cycles; idle cycles drain the oldest queued word.
    task automatic model(input logic rq_i, input logic [15:0] ra, input logic wq,
                         input logic [15:0] wa, input logic [15:0] wd, input logic clr);
        int    sz;
        logic  frc, popped, dropped;
        fent_t e;
        sz = mq.size();
        frc = rq_i && (waited == STARVE_MAX) && (sz > 0);
        popped = 1'b0;
        dropped = 1'b0;
        if (rq_i && !frc) begin
            exp_rd.push_back('{data: mmem[ra[7:0]], cyc: cyc + 32'(1 + RD_LAT)});
        end else if (sz > 0) begin
            e = mq.pop_front();
            exp_wr.push_back('{addr: e.addr, data: e.data, forced: frc, cyc: cyc + 32'd1});
            mmem[e.addr[7:0]] = e.data;
            popped = 1'b1;
        end
        if (sz == 0 || popped) waited = 0;
        else if (waited < STARVE_MAX) waited++;
        if (wq) begin
            if (mq.size() < DEPTH) mq.push_back('{addr: wa, data: wd});
            else dropped = 1'b1;
        end
        if (dropped) exp_ovf = 1'b1;
        else if (clr) exp_ovf = 1'b0;
    endtask

    task automatic step(input logic rq_i, input logic [15:0] ra, input logic wq,
                        input logic [15:0] wa, input logic [15:0] wd, input logic clr);
        @(posedge clk);
        #2;
        bus.rd_req  = rq_i;
        bus.rd_addr = ra;
        bus.wr_req  = wq;
        bus.wr_addr = wa;
        bus.wr_data = wd;
        bus.ovf_clr = clr;
        model(rq_i, ra, wq, wa, wd, clr);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 16'h0, 1'b0, 16'h0, 16'h0, 1'b0);
    endtask

    // Called 2 time units after a rising edge.
    task automatic do_reset();
        bus.rd_req = 1'b0; bus.wr_req = 1'b0; bus.ovf_clr = 1'b0;
        rst = 1'b1;
        mq.delete(); exp_wr.delete(); exp_rd.delete();
        waited = 0;
        exp_ovf = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    // Monitor: pops expectations whenever the DUT presents a RAM write or a read response.
    initial begin
        wexp_t we_e;
        rexp_t re_e;
        forever begin
            @(posedge clk);
            #1;
            if (!rst) begin
                if (bus.ram_we) begin
                    if (exp_wr.size() == 0) begin
                        fail_now("unexpected_write", $sformatf("addr %h data %h, none expected", bus.ram_addr, bus.ram_wdata));
                    end else begin
                        we_e = exp_wr.pop_front();
                        chk("ram_write{addr,data,miss,cyc}", {bus.ram_addr, bus.ram_wdata, bus.rd_miss, cyc}, 96'(we_e));
                    end
                end else if (bus.rd_miss) begin
                    fail_now("rd_miss_without_write", "rd_miss high while ram_we low");
                end
                if (bus.rd_miss) n_miss_seen++;
                if (bus.rd_valid) begin
                    if (exp_rd.size() == 0) begin
                        fail_now("unexpected_rd_valid", $sformatf("rd_data %h, none expected", bus.rd_data));
                    end else begin
                        re_e = exp_rd.pop_front();
                        chk("read{data,cyc}", {bus.rd_data, cyc}, 96'(re_e));
                    end
                end
                if (exp_wr.size() > 0 && exp_wr[0].cyc < cyc) begin
                    we_e = exp_wr.pop_front();
                    fail_now("missing_write", $sformatf("addr %h data %h due cycle %0d not seen", we_e.addr, we_e.data, we_e.cyc));
                end
                if (exp_rd.size() > 0 && exp_rd[0].cyc < cyc) begin
                    re_e = exp_rd.pop_front();
                    fail_now("missing_read", $sformatf("data %h due cycle %0d not seen", re_e.data, re_e.cyc));
                end
                chk("wr_ovf", 96'(bus.wr_ovf), 96'(exp_ovf));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int m0, seg_len, pct;
        logic rqr, wqr;
        for (int i = 0; i < 256; i++) mmem[i] = init_val(16'(i));
        bus.wr_req = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.rd_req = 1'b0; bus.rd_addr = '0; bus.ovf_clr = 1'b0;
        #2;
        do_reset();
        #1;
        chk("reset_outputs", {bus.ram_we, bus.rd_valid, bus.rd_miss, bus.wr_ovf, bus.ram_addr, bus.ram_wdata, bus.rd_data}, 96'd0);
`ifdef ARB_STAT_EN
        chk("reset_stats", {bus.stat_wr_cnt, bus.stat_drop_cnt, bus.stat_miss_cnt}, 96'd0);
`endif

        // 1: three writes on an idle RAM.
        step(1'b0, 16'h0, 1'b1, 16'h0000, 16'hA0A0, 1'b0);
        step(1'b0, 16'h0, 1'b1, 16'h0001, 16'hA1A1, 1'b0);
        step(1'b0, 16'h0, 1'b1, 16'h0002, 16'hA2A2, 1'b0);
        idle(5);

        // 2: continuous reads of a preloaded word.
        for (int i = 0; i < 8; i++) step(1'b1, 16'h0010, 1'b0, 16'h0, 16'h0, 1'b0);
        idle(3);

        // 3: one write starved by back-to-back reads.
        m0 = n_miss_seen;
        step(1'b1, 16'h0010, 1'b1, 16'h0030, 16'hBEEF, 1'b0);
        for (int i = 0; i < 70; i++) step(1'b1, 16'h0001, 1'b0, 16'h0, 16'h0, 1'b0);
        idle(3);
        chk("miss_once", 96'(n_miss_seen - m0), 96'd1);

        // 4: six writes into a four-deep FIFO while reads block it.
        for (int i = 0; i < 6; i++)
            step(1'b1, 16'h0002, 1'b1, 16'(16'h0040 + i), 16'(16'hC000 + i), 1'b0);
        step(1'b1, 16'h0002, 1'b0, 16'h0, 16'h0, 1'b0);
        chk("ovf_set", 96'(bus.wr_ovf), 96'd1);
        for (int i = 0; i < 140; i++) step(1'b1, 16'h0041, 1'b0, 16'h0, 16'h0, 1'b0);
        idle(6);
        step(1'b0, 16'h0, 1'b0, 16'h0, 16'h0, 1'b1);
        step(1'b0, 16'h0, 1'b0, 16'h0, 16'h0, 1'b0);
        chk("ovf_cleared", 96'(bus.wr_ovf), 96'd0);

        // 5: full FIFO, new write coinciding with a pop.
        for (int i = 0; i < 4; i++)
            step(1'b1, 16'h0003, 1'b1, 16'(16'h0050 + i), 16'(16'hD000 + i), 1'b0);
        step(1'b0, 16'h0, 1'b1, 16'h0060, 16'hD0D0, 1'b0);
        idle(8);
        chk("no_drop_on_pop", 96'(bus.wr_ovf), 96'd0);

        // 6: reset with two writes queued while a write and a read are on the RAM port.
        for (int i = 0; i < 3; i++)
            step(1'b1, 16'h0004, 1'b1, 16'(16'h0070 + i), 16'(16'hE000 + i), 1'b0);
        step(1'b1, 16'h0010, 1'b0, 16'h0, 16'h0, 1'b0);
        step(1'b0, 16'h0, 1'b0, 16'h0, 16'h0, 1'b0);
        @(posedge clk);
        #2;
        chk("pre_rst_we_rdv", {bus.ram_we, bus.rd_valid}, 96'b11);
        rst = 1'b1;
        #1;
        chk("async_rst_we_rdv", {bus.ram_we, bus.rd_valid}, 96'b00);
        #1;
        do_reset();
`ifdef ARB_STAT_EN
        #1;
        chk("mid_reset_stats", {bus.stat_wr_cnt, bus.stat_drop_cnt, bus.stat_miss_cnt}, 96'd0);
`endif
        idle(12);
        chk("rd_data_after_rst", 96'(bus.rd_data), 96'd0);

        // Random traffic with read-density segments.
        for (int s = 0; s < 12; s++) begin
            seg_len = $urandom_range(20, 90);
            pct = ($urandom_range(0, 3) == 0) ? 100 : $urandom_range(0, 100);
            for (int i = 0; i < seg_len; i++) begin
                rqr = ($urandom_range(0, 99) < pct);
                wqr = ($urandom_range(0, 3) == 0);
                step(rqr, 16'($urandom_range(0, 15)), wqr, 16'($urandom_range(0, 15)),
                     16'($urandom_range(0, 65535)), ($urandom_range(0, 15) == 0));
            end
        end

        for (int i = 0; i < 300 && (mq.size() + exp_wr.size() + exp_rd.size()) != 0; i++) idle(1);
        idle(2);
        chk("drain_wr_sb_empty", 96'(exp_wr.size() + mq.size()), 96'd0);
        chk("drain_rd_sb_empty", 96'(exp_rd.size()), 96'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
        $finish;
    end
endmodule
